drm_input_buffer_writer: RTL and testbench

//  Per-user write-address generator and write-port driver for the de-rate-matching input buffer.

---
 rtl/drm_pkg.sv | 37 +++
 rtl/drm_input_buffer_writer_if.sv | 56 +++++
 rtl/drm_user_addr_ctr.sv | 132 +++++++++++++
 rtl/drm_input_buffer_writer.sv | 161 ++++++++++++++++
 tb/tb_drm_input_buffer_writer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/drm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : drm_pkg                                                      |
// | Description : Shared types, default sizing and lane-mask helper for the    |
// |               de-rate-matching input buffer writer.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package drm_pkg;

    localparam int DEF_NUM_USERS  = 8;
    localparam int DEF_UIDX_W     = 4;
    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_LANE_W     = 4;
    localparam int DEF_MAX_LAYERS = 2;
    localparam int DEF_SAMPLE_W   = 48;
    localparam int DEF_LANES      = 2 ** DEF_LANE_W;
    // Width of each per-user start/length field in the packed configuration buses
    localparam int FIELD_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } user_state_e;

    // Contiguous run of 'step' ones starting at lane 'base'; lanes past the top drop out
    function automatic logic [DEF_LANES-1:0] lane_mask(
        input logic [DEF_LANE_W-1:0] base,
        input logic [2:0]            step
    );
        logic [DEF_LANES-1:0] ones;
        ones = (DEF_LANES'(1) << step) - DEF_LANES'(1);
        return ones << base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drm_input_buffer_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : drm_input_buffer_writer_if                                   |
// | Description : Slot control, demux strobe and RAM write-port bundle for the |
// |               input buffer writer.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface drm_input_buffer_writer_if
    import drm_pkg::*;
#(
    parameter int NUM_USERS  = DEF_NUM_USERS,
    parameter int UIDX_W     = DEF_UIDX_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LANE_W     = DEF_LANE_W,
    parameter int MAX_LAYERS = DEF_MAX_LAYERS,
    parameter int SAMPLE_W   = DEF_SAMPLE_W
) ();

    logic                                 i_rdm_slot_start;
    logic                                 i_rdm_slot_end;
    logic [UIDX_W-1:0]                    i_user_num;
    logic [1:0]                           i_layer_num;
    logic [NUM_USERS*FIELD_W-1:0]         i_users_buf_start;
    logic [NUM_USERS*FIELD_W-1:0]         i_users_buf_len;
    logic [UIDX_W-1:0]                    i_demux_user_idx;
    logic                                 i_demux_strb;
    logic [MAX_LAYERS*SAMPLE_W-1:0]       i_demux_rx;

    logic                                 o_wr_en;
    logic [ADDR_W-LANE_W:0]               o_wr_addr;
    logic [(2**LANE_W)-1:0]               o_wr_lane_mask;
    logic [(2**LANE_W)*SAMPLE_W-1:0]      o_wr_data;
    logic [NUM_USERS-1:0]                 o_user_pp;
    logic [NUM_USERS-1:0]                 o_user_full;
    logic                                 o_err_overflow;
    logic                                 o_err_idx;
    logic                                 o_err_align;

    modport master (
        output i_rdm_slot_start, i_rdm_slot_end, i_user_num, i_layer_num,
               i_users_buf_start, i_users_buf_len, i_demux_user_idx,
               i_demux_strb, i_demux_rx,
        input  o_wr_en, o_wr_addr, o_wr_lane_mask, o_wr_data, o_user_pp,
               o_user_full, o_err_overflow, o_err_idx, o_err_align
    );

    modport slave (
        input  i_rdm_slot_start, i_rdm_slot_end, i_user_num, i_layer_num,
               i_users_buf_start, i_users_buf_len, i_demux_user_idx,
               i_demux_strb, i_demux_rx,
        output o_wr_en, o_wr_addr, o_wr_lane_mask, o_wr_data, o_user_pp,
               o_user_full, o_err_overflow, o_err_idx, o_err_align
    );

endinterface
`default_nettype wire

// File: rtl/drm_user_addr_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : drm_user_addr_ctr                                            |
// | Description : One user channel: IDLE/ACTIVE/FULL state, write address,     |
// |               group count, latched step/length and ping-pong half.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module drm_user_addr_ctr
    import drm_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = FIELD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_slot_start,
    input  logic              i_slot_end,
    input  logic              i_enable,
    input  logic [2:0]        i_step,
    input  logic [ADDR_W-1:0] i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_hit,
    output logic              o_accept,
    output logic [ADDR_W-1:0] o_addr_pre,
    output logic [2:0]        o_step_pre,
    output logic              o_pp_pre,
    output logic              o_align_err,
    output logic              o_pp,
    output logic              o_full
);

    localparam int c_sum_w = LEN_W + 1;

    user_state_e        r_state, w_state_pre, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_pre, w_addr_nxt, w_start_aligned;
    logic [LEN_W-1:0]   r_count, w_count_pre, w_count_nxt;
    logic [LEN_W-1:0]   r_len, w_len_pre;
    logic [c_sum_w-1:0] w_count_sum;
    logic [2:0]         r_step, w_step_pre;
    logic               r_pp, w_pp_pre, w_pp_nxt;
    logic               w_accept;
    logic               w_align_err;

    // Round the programmed start down to a multiple of the layer step
    always_comb begin
        w_start_aligned = i_start;
        case (i_step)
            3'd2:    w_start_aligned = {i_start[ADDR_W-1:1], 1'b0};
            3'd3:    w_start_aligned = i_start - (i_start % ADDR_W'(3));
            3'd4:    w_start_aligned = {i_start[ADDR_W-1:2], 2'b00};
            default: w_start_aligned = i_start;
        endcase
    end

    // Event ordering: slot_end closes, slot_start reloads, strobe is judged on the
    // reloaded state; a lone slot_end is applied after the strobe has been taken
    always_comb begin
        w_state_pre = r_state;
        w_addr_pre  = r_addr;
        w_count_pre = r_count;
        w_len_pre   = r_len;
        w_step_pre  = r_step;
        w_pp_pre    = r_pp;
        w_align_err = 1'b0;

        if (i_slot_start) begin
            if (i_slot_end && (r_state != ST_IDLE)) begin
                w_pp_pre = ~r_pp;
            end
            if (i_enable) begin
                w_addr_pre  = w_start_aligned;
                w_align_err = (w_start_aligned != i_start);
                w_count_pre = '0;
                w_len_pre   = i_len;
                w_step_pre  = i_step;
                w_state_pre = (i_len == '0) ? ST_FULL : ST_ACTIVE;
            end else begin
                w_state_pre = ST_IDLE;
            end
        end

        w_accept    = i_hit && (w_state_pre == ST_ACTIVE);

        w_state_nxt = w_state_pre;
        w_addr_nxt  = w_addr_pre;
        w_count_nxt = w_count_pre;
        w_pp_nxt    = w_pp_pre;
        w_count_sum = {1'b0, w_count_pre} + c_sum_w'(w_step_pre);

        if (w_accept) begin
            w_addr_nxt  = w_addr_pre + ADDR_W'(w_step_pre);
            w_count_nxt = w_count_sum[LEN_W-1:0];
            if (w_count_sum >= {1'b0, w_len_pre}) begin
                w_state_nxt = ST_FULL;
            end
        end

        if (i_slot_end && !i_slot_start && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_pp_nxt    = ~r_pp;
        end
    end

    // Channel state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_len   <= '0;
            r_step  <= '0;
            r_pp    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_count <= w_count_nxt;
            r_len   <= w_len_pre;
            r_step  <= w_step_pre;
            r_pp    <= w_pp_nxt;
        end
    end

    assign o_accept    = w_accept;
    assign o_addr_pre  = w_addr_pre;
    assign o_step_pre  = w_step_pre;
    assign o_pp_pre    = w_pp_pre;
    assign o_align_err = w_align_err;
    assign o_pp        = r_pp;
    assign o_full      = (r_state == ST_FULL);

endmodule
`default_nettype wire

// File: rtl/drm_input_buffer_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : drm_input_buffer_writer                                      |
// | Description : Per-user write-address generator and registered write-port   |
// |               driver for the de-rate-matching input buffer RAM.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module drm_input_buffer_writer
    import drm_pkg::*;
#(
    parameter int NUM_USERS  = DEF_NUM_USERS,
    parameter int UIDX_W     = DEF_UIDX_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    // lane_mask() is sized by DEF_LANE_W, so LANE_W must stay at that value
    parameter int LANE_W     = DEF_LANE_W,
    parameter int MAX_LAYERS = DEF_MAX_LAYERS,
    parameter int SAMPLE_W   = DEF_SAMPLE_W
) (
    input logic                      i_core_clk,
    input logic                      i_rx_rst,
    drm_input_buffer_writer_if.slave bus
);

    localparam int c_lanes   = 2 ** LANE_W;
    localparam int c_hi_w    = FIELD_W - ADDR_W;

    logic [2:0]                     w_layer_step;
    logic                           w_idx_ok;
    logic                           w_idx_err;
    logic [NUM_USERS-1:0]           w_hit;
    logic [NUM_USERS-1:0]           w_accept;
    logic [NUM_USERS-1:0]           w_align;
    logic [NUM_USERS-1:0]           w_pp_pre;
    logic [NUM_USERS-1:0]           w_pp;
    logic [NUM_USERS-1:0]           w_full;
    logic [ADDR_W-1:0]              w_addr_pre [NUM_USERS];
    logic [2:0]                     w_step_pre [NUM_USERS];
    logic [NUM_USERS*c_hi_w-1:0]    w_unused_start_hi;

    logic                           w_any_accept;
    logic [ADDR_W-1:0]              w_sel_addr;
    logic [2:0]                     w_sel_step;
    logic                           w_sel_pp;
    logic [LANE_W-1:0]              w_lane_base;
    logic [c_lanes-1:0]             w_mask;
    logic [c_lanes*SAMPLE_W-1:0]    w_data;

    logic                           r_wr_en;
    logic [ADDR_W-LANE_W:0]         r_wr_addr;
    logic [c_lanes-1:0]             r_wr_mask;
    logic [c_lanes*SAMPLE_W-1:0]    r_wr_data;
    logic                           r_err_idx;
    logic                           r_err_ovf;
    logic                           r_err_align;

    // Layer step for the coming slot, capped at the number of demux layers
    always_comb begin
        w_layer_step = {1'b0, bus.i_layer_num} + 3'd1;
        if (w_layer_step > 3'(MAX_LAYERS)) begin
            w_layer_step = 3'(MAX_LAYERS);
        end
    end

    assign w_idx_ok  = bus.i_demux_strb && (bus.i_demux_user_idx < bus.i_user_num);
    assign w_idx_err = bus.i_demux_strb && !(bus.i_demux_user_idx < bus.i_user_num);

    generate
        for (genvar u = 0; u < NUM_USERS; u++) begin : g_user
            localparam logic [UIDX_W-1:0] c_uid = UIDX_W'(u);

            assign w_hit[u] = w_idx_ok && (bus.i_demux_user_idx == c_uid);
            assign w_unused_start_hi[u*c_hi_w +: c_hi_w] =
                bus.i_users_buf_start[u*FIELD_W + ADDR_W +: c_hi_w];

            drm_user_addr_ctr #(
                .ADDR_W (ADDR_W),
                .LEN_W  (FIELD_W)
            ) u_ctr (
                .i_clk        (i_core_clk),
                .i_rst        (i_rx_rst),
                .i_slot_start (bus.i_rdm_slot_start),
                .i_slot_end   (bus.i_rdm_slot_end),
                .i_enable     (c_uid < bus.i_user_num),
                .i_step       (w_layer_step),
                .i_start      (bus.i_users_buf_start[u*FIELD_W +: ADDR_W]),
                .i_len        (bus.i_users_buf_len[u*FIELD_W +: FIELD_W]),
                .i_hit        (w_hit[u]),
                .o_accept     (w_accept[u]),
                .o_addr_pre   (w_addr_pre[u]),
                .o_step_pre   (w_step_pre[u]),
                .o_pp_pre     (w_pp_pre[u]),
                .o_align_err  (w_align[u]),
                .o_pp         (w_pp[u]),
                .o_full       (w_full[u])
            );
        end
    endgenerate

    // At most one user accepts per cycle, so an OR-mux picks its write context
    always_comb begin
        w_sel_addr = '0;
        w_sel_step = '0;
        w_sel_pp   = 1'b0;
        for (int u = 0; u < NUM_USERS; u++) begin
            if (w_accept[u]) begin
                w_sel_addr = w_sel_addr | w_addr_pre[u];
                w_sel_step = w_sel_step | w_step_pre[u];
                w_sel_pp   = w_sel_pp | w_pp_pre[u];
            end
        end
    end

    assign w_any_accept = |w_accept;
    assign w_lane_base  = w_sel_addr[LANE_W-1:0];
    assign w_mask       = lane_mask(w_lane_base, w_sel_step);

    // Steer layer L onto lane base+L; all other lanes stay zero
    always_comb begin
        w_data = '0;
        for (int j = 0; j < c_lanes; j++) begin
            for (int l = 0; l < MAX_LAYERS; l++) begin
                if ((l < int'(w_sel_step)) && (j == int'(w_lane_base) + l)) begin
                    w_data[j*SAMPLE_W +: SAMPLE_W] = bus.i_demux_rx[l*SAMPLE_W +: SAMPLE_W];
                end
            end
        end
    end

    // Write-port and error-pulse register; reset drops any pending write
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_mask   <= '0;
            r_wr_data   <= '0;
            r_err_idx   <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            r_wr_en     <= w_any_accept;
            r_wr_addr   <= w_any_accept ? {w_sel_pp, w_sel_addr[ADDR_W-1:LANE_W]} : '0;
            r_wr_mask   <= w_any_accept ? w_mask : '0;
            r_wr_data   <= w_any_accept ? w_data : '0;
            r_err_idx   <= w_idx_err;
            r_err_ovf   <= w_idx_ok && !w_any_accept;
            r_err_align <= |w_align;
        end
    end

    assign bus.o_wr_en        = r_wr_en;
    assign bus.o_wr_addr      = r_wr_addr;
    assign bus.o_wr_lane_mask = r_wr_mask;
    assign bus.o_wr_data      = r_wr_data;
    assign bus.o_user_pp      = w_pp;
    assign bus.o_user_full    = w_full;
    assign bus.o_err_overflow = r_err_ovf;
    assign bus.o_err_idx      = r_err_idx;
    assign bus.o_err_align    = r_err_align;

endmodule
`default_nettype wire

// File: tb/tb_drm_input_buffer_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_drm_input_buffer_writer                                   |
// | Description : Table-driven self-checking bench for drm_input_buffer_writer |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_drm_input_buffer_writer;

    localparam int c_nvec = 22;

    typedef struct {
        logic        ss;
        logic        se;
        logic [3:0]  unum;
        logic [1:0]  lnum;
        logic        strb;
        logic [3:0]  idx;
        logic        wen;
        logic [10:0] waddr;
        logic [15:0] mask;
        logic        ovf;
        logic        eidx;
        logic        ealign;
        logic [7:0]  pp;
        logic [7:0]  full;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [c_nvec];

    drm_input_buffer_writer_if bus ();

    drm_input_buffer_writer dut (
        .i_core_clk (clk),
        .i_rx_rst   (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic ss, input logic se, input logic [3:0] unum, input logic [1:0] lnum,
        input logic strb, input logic [3:0] idx, input logic wen, input logic [10:0] waddr,
        input logic [15:0] mask, input logic ovf, input logic eidx, input logic ealign,
        input logic [7:0] pp, input logic [7:0] full
    );
        vec_t v;
        v.ss = ss; v.se = se; v.unum = unum; v.lnum = lnum; v.strb = strb; v.idx = idx;
        v.wen = wen; v.waddr = waddr; v.mask = mask; v.ovf = ovf; v.eidx = eidx;
        v.ealign = ealign; v.pp = pp; v.full = full;
        return v;
    endfunction

    task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] layer_word(input int row, input int l);
        logic [15:0] tag;
        tag = (l == 0) ? 16'hA000 : 16'hB000;
        return {tag | 16'(row), (l == 0) ? 32'h1234_5678 : 32'h9ABC_DEF0};
    endfunction

    function automatic logic [767:0] exp_data(input int row, input vec_t v);
        logic [767:0] d;
        int base;
        d    = '0;
        base = 0;
        if (v.wen) begin
            for (int b = 15; b >= 0; b--) begin
                if (((v.mask >> b) & 16'h1) != 16'h0) base = b;
            end
            for (int l = 0; l <= int'(v.lnum); l++) begin
                d = d | (768'(layer_word(row, l)) << ((base + l) * 48));
            end
        end
        return d;
    endfunction

    task automatic drive(input vec_t v, input int row);
        bus.i_rdm_slot_start = v.ss;
        bus.i_rdm_slot_end   = v.se;
        bus.i_user_num       = v.unum;
        bus.i_layer_num      = v.lnum;
        bus.i_demux_strb     = v.strb;
        bus.i_demux_user_idx = v.idx;
        bus.i_demux_rx       = {layer_word(row, 1), layer_word(row, 0)};
    endtask

    task automatic check_row(input string tag, input vec_t v, input logic [767:0] d);
        check({tag, " wr_en"},     768'(bus.o_wr_en),        768'(v.wen));
        check({tag, " wr_addr"},   768'(bus.o_wr_addr),      768'(v.waddr));
        check({tag, " lane_mask"}, 768'(bus.o_wr_lane_mask), 768'(v.mask));
        check({tag, " wr_data"},   bus.o_wr_data,            d);
        check({tag, " err_ovf"},   768'(bus.o_err_overflow), 768'(v.ovf));
        check({tag, " err_idx"},   768'(bus.o_err_idx),      768'(v.eidx));
        check({tag, " err_align"}, 768'(bus.o_err_align),    768'(v.ealign));
        check({tag, " user_pp"},   768'(bus.o_user_pp),      768'(v.pp));
        check({tag, " user_full"}, 768'(bus.o_user_full),    768'(v.full));
    endtask

    initial begin
        vec_t z;
        // Slot 1: one layer, user 0 only, start 0x0010 len 4
        vecs[0]  = mk(1,0,4'd1,2'd0,0,4'd0, 0,11'h000,16'h0000,0,0,0,8'h00,8'h00);
        vecs[1]  = mk(0,0,4'd1,2'd0,1,4'd0, 1,11'h001,16'h0001,0,0,0,8'h00,8'h00);
        vecs[2]  = mk(0,0,4'd1,2'd0,1,4'd0, 1,11'h001,16'h0002,0,0,0,8'h00,8'h00);
        vecs[3]  = mk(0,0,4'd1,2'd0,1,4'd0, 1,11'h001,16'h0004,0,0,0,8'h00,8'h00);
        vecs[4]  = mk(0,0,4'd1,2'd0,1,4'd0, 1,11'h001,16'h0008,0,0,0,8'h00,8'h01);
        vecs[5]  = mk(0,0,4'd1,2'd0,1,4'd0, 0,11'h000,16'h0000,1,0,0,8'h00,8'h01);
        vecs[6]  = mk(0,0,4'd1,2'd0,1,4'd5, 0,11'h000,16'h0000,0,1,0,8'h00,8'h01);
        vecs[7]  = mk(0,1,4'd1,2'd0,0,4'd0, 0,11'h000,16'h0000,0,0,0,8'h01,8'h00);
        // Slot 2: two layers, four users; users 1 and 2 have odd starts
        vecs[8]  = mk(1,0,4'd4,2'd1,0,4'd0, 0,11'h000,16'h0000,0,0,1,8'h01,8'h00);
        vecs[9]  = mk(0,0,4'd4,2'd1,1,4'd3, 1,11'h001,16'hC000,0,0,0,8'h01,8'h00);
        vecs[10] = mk(0,0,4'd4,2'd1,1,4'd3, 1,11'h002,16'h0003,0,0,0,8'h01,8'h00);
        vecs[11] = mk(0,0,4'd4,2'd1,1,4'd3, 1,11'h002,16'h000C,0,0,0,8'h01,8'h08);
        vecs[12] = mk(0,0,4'd4,2'd1,1,4'd0, 1,11'h401,16'h0003,0,0,0,8'h01,8'h08);
        vecs[13] = mk(0,0,4'd4,2'd1,1,4'd2, 1,11'h002,16'h0003,0,0,0,8'h01,8'h08);
        vecs[14] = mk(0,0,4'd4,2'd1,1,4'd5, 0,11'h000,16'h0000,0,1,0,8'h01,8'h08);
        vecs[15] = mk(0,1,4'd4,2'd1,1,4'd0, 1,11'h401,16'h000C,0,0,0,8'h0E,8'h00);
        // Slot 3: wrap at 0x3FFF with a strobe on the slot_start cycle
        vecs[16] = mk(1,0,4'd2,2'd0,1,4'd1, 1,11'h7FF,16'h8000,0,0,0,8'h0E,8'h00);
        vecs[17] = mk(0,0,4'd2,2'd0,1,4'd1, 1,11'h400,16'h0001,0,0,0,8'h0E,8'h00);
        vecs[18] = mk(0,0,4'd2,2'd0,1,4'd3, 0,11'h000,16'h0000,0,1,0,8'h0E,8'h00);
        // slot_end + slot_start + strobe together: close, reload, then accept
        vecs[19] = mk(1,1,4'd1,2'd0,1,4'd0, 1,11'h401,16'h0001,0,0,0,8'h0D,8'h00);
        vecs[20] = mk(0,0,4'd1,2'd0,1,4'd1, 0,11'h000,16'h0000,0,1,0,8'h0D,8'h00);
        vecs[21] = mk(0,0,4'd1,2'd0,1,4'd0, 1,11'h401,16'h0002,0,0,0,8'h0D,8'h00);

        rst = 1'b1;
        z = mk(0,0,4'd0,2'd0,0,4'd0, 0,11'h000,16'h0000,0,0,0,8'h00,8'h00);
        drive(z, 0);
        bus.i_users_buf_start = '0;
        bus.i_users_buf_len   = '0;
        bus.i_users_buf_start[0*16 +: 16] = 16'h0010; bus.i_users_buf_len[0*16 +: 16] = 16'd4;
        bus.i_users_buf_start[1*16 +: 16] = 16'h3FFF; bus.i_users_buf_len[1*16 +: 16] = 16'd8;
        bus.i_users_buf_start[2*16 +: 16] = 16'h0021; bus.i_users_buf_len[2*16 +: 16] = 16'd4;
        bus.i_users_buf_start[3*16 +: 16] = 16'h001E; bus.i_users_buf_len[3*16 +: 16] = 16'd6;

        repeat (3) @(negedge clk);
        check_row("reset", z, '0);
        rst = 1'b0;

        for (int i = 0; i < c_nvec; i++) begin
            drive(vecs[i], i);
            @(negedge clk);
            check_row($sformatf("vec%0d", i), vecs[i], exp_data(i, vecs[i]));
        end

        // Reset on the same cycle as an accepted strobe: the write is dropped
        rst = 1'b1;
        drive(mk(0,0,4'd1,2'd0,1,4'd0, 0,0,0,0,0,0,0,0), 30);
        @(negedge clk);
        check_row("rst_mid_slot", z, '0);

        // After reset every user is IDLE, so a valid-index strobe overflows
        rst = 1'b0;
        drive(mk(0,0,4'd1,2'd0,1,4'd0, 0,0,0,0,0,0,0,0), 31);
        @(negedge clk);
        check_row("post_rst_strobe", mk(0,0,4'd1,2'd0,1,4'd0, 0,11'h000,16'h0000,1,0,0,8'h00,8'h00), '0);

        drive(z, 0);
        @(negedge clk);
        check_row("idle_end", z, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
